// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the core's
// load/store port. Requests are latched in IDLE, a programmable wait-state
// counter delays the access, and the result is held in RESP until the core
// takes it. Misaligned or out-of-range accesses return an error and leave
// storage untouched.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; req_ready=1
// WAIT  | request latched; counting down wait states, access when cnt==0
// RESP  | response held on rsp_* until rsp_ready handshake
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_write;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic [31:0]   r_rdata;
  logic          r_err;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_access;
  logic          w_err;
  logic [AW-1:0] w_idx;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_access = (r_state == S_WAIT) && (r_cnt == '0);
  // Full 30-bit word index is compared so high addresses never alias into storage.
  assign w_err    = (r_addr[1:0] != 2'b00) ||
                    ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_idx    = r_addr[AW+1:2];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded handshake outputs.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Request capture and wait-state countdown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_cnt   <= CW'(WAIT_CYCLES);
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  // Response capture at the access edge; held untouched through RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_err   <= w_err;
      r_rdata <= (w_err || r_write) ? 32'h0 : r_mem[w_idx];
    end
  end

  // Byte-lane storage writes; storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (w_access && r_write && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plan plus randomized loads/stores checked
// against a word-array reference model; a second instance with zero wait
// states checks the back-to-back transaction rhythm.
module tb_dmem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 256;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  logic        reset0;
  logic        req_ready0;
  logic        rsp_valid0;
  logic [31:0] rsp_rdata0;
  logic        rsp_err0;
  logic        busy0;

  logic [31:0] mdl [DEPTH];
  int          n_cmp;
  int          n_bad;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clock(clock), .reset(reset0),
    .req_valid(1'b1), .req_ready(req_ready0), .req_write(1'b0),
    .req_addr(32'h0), .req_wdata(32'h0), .req_be(4'h0),
    .rsp_valid(rsp_valid0), .rsp_ready(1'b1), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .busy(busy0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input int hold);
    logic        exp_e;
    logic [31:0] exp_d;
    int          cyc;
    exp_e = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
    exp_d = 32'h0;
    if (!exp_e && !wr) exp_d = mdl[addr[31:2]];
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    if (wr && !exp_e)
      for (int i = 0; i < 4; i++)
        if (be[i]) mdl[addr[31:2]][8*i +: 8] = wd[8*i +: 8];
    cyc = 0;
    do begin
      @(posedge clock); cyc++;
      @(negedge clock);
      chk("busy_active", busy, 1);
    end while (!rsp_valid && cyc < 20);
    chk("latency", cyc, W + 1);
    chk("rdata", rsp_rdata, exp_d);
    chk("err", rsp_err, exp_e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, exp_d);
      chk("hold_err", rsp_err, exp_e);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("post_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [31:0] a;
    int          sel;
    int          idx;
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; reset0 = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_be = 4'hF;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_vals("reset");
    req_valid = 1'b0;
    reset = 1'b0;

    // Initialise the word pool used by later loads: indices 0..15 and the last word.
    for (int i = 0; i < 17; i++) begin
      idx = (i == 16) ? DEPTH - 1 : i;
      txn(1'b1, 32'(idx) << 2, $urandom, 4'hF, 0);
    end

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("plan_full_word", mdl[4], 32'hDEADBEEF);
    txn(1'b1, 32'h10, 32'h000000AA, 4'b0001, 1);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, 2);
    chk("plan_partial", mdl[4], 32'hDEADBEAA);
    txn(1'b0, 32'h12, 32'h0, 4'h0, 0);
    txn(1'b0, 32'h400, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h402, 32'h55555555, 4'hF, 0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0);
    txn(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5);

    // Reset in WAIT with one wait state left: store must be discarded.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("wait_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_wait");
    @(negedge clock);
    reset = 1'b0;
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0);

    // Reset in RESP: response dropped.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (W + 1) @(posedge clock);
    @(negedge clock);
    chk("resp_valid_before_rst", rsp_valid, 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_resp");
    @(negedge clock);
    reset = 1'b0;

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      idx = $urandom_range(0, 16);
      if (idx == 16) idx = DEPTH - 1;
      a = 32'(idx) << 2;
      if (sel == 7) a = a | 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'(DEPTH) << 2;
      else if (sel == 9) a = {$urandom_range(1, 32'h3FFFFFFF) | 32'h100, 2'b00} & 32'hFFFFFFFC;
      if (sel == 9 && a[31:2] < 30'(DEPTH)) a = 32'hFFFFFFFC;
      txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    // Zero-wait-state instance: accept, WAIT, RESP repeating every 3 cycles.
    reset0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("w0_req_ready", req_ready0, (i % 3) == 0);
      chk("w0_rsp_valid", rsp_valid0, (i % 3) == 2);
      chk("w0_busy", busy0, (i % 3) != 0);
      chk("w0_err", rsp_err0, 0);
      @(negedge clock);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
